ifu_fetch: RTL and testbench

Instruction fetch unit sitting directly upstream of the single-cycle `npc` core. It replaces the C-side instruction fetch with an in-RTL fetch path. It owns the fetch PC, issues one word-aligned read at a time to instruction memory over a valid/ready request channel, and buffers returned words in a small FIFO. It presents each word to the core's decoder as `{inst, inst_pc, inst_err}` with a valid/ready handshake. The core redirects it on jumps and branches.

---
 rtl/ifu_fetch.sv | 218 +++++++++++++++++++++
 tb/tb_ifu_fetch.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the fetch PC and issues single-outstanding word reads to
// instruction memory. Returned words are buffered in a small FIFO and
// presented to the decoder as {inst, inst_pc, inst_err}.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no request in flight; waiting for FIFO space
//   S_REQ  | request presented, address held stable until accepted
//   S_WAIT | request accepted, waiting for the single response
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   req_pc;
  logic [31:0]   redir_pc;
  logic          drop;
  logic          drop_next;

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [31:0]   data_q [FIFO_DEPTH];
  logic          err_q  [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          resp_fire;
  logic          space;
  logic          load_req;

  // Low address bits of a redirect target are forced to zero.
  logic          unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_pc = {redirect_pc[31:2], 2'b00};

  // Head of the FIFO; fields read as zero while the buffer is empty.
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? data_q[rd_ptr] : 32'd0;
  assign inst_pc    = inst_valid ? pc_q[rd_ptr]   : 32'd0;
  assign inst_err   = inst_valid ? err_q[rd_ptr]  : 1'b0;

  // Per-cycle events, post-update occupancy and the next fetch address.
  // A response coinciding with a redirect is discarded, as is any response
  // whose request was overtaken by a redirect (drop set).
  always_comb begin
    pop        = inst_valid & inst_ready;
    resp_fire  = (state == S_WAIT) & imem_resp_valid;
    push       = resp_fire & ~drop & ~redirect_valid;
    count_next = count;
    if (redirect_valid) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(push) - CW'(pop);
    end
    space = (count_next < DEPTH_C);
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next = redir_pc;
    end else if (push) begin
      fetch_pc_next = req_pc + 32'd4;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; load_req marks entry into S_REQ with a fresh address.
  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (space) begin
          state_next = S_REQ;
          load_req   = 1'b1;
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (space) begin
            state_next = S_REQ;
            load_req   = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Drop tracking: a redirect with a request presented or in flight marks
  // that transaction stale; its response retires it and clears the flag.
  // A redirect landing on the response cycle itself needs no flag because
  // that response is discarded directly.
  always_comb begin
    drop_next = drop;
    if (resp_fire) begin
      drop_next = 1'b0;
    end else if (redirect_valid && (state != S_IDLE)) begin
      drop_next = 1'b1;
    end
  end

  // Fetch PC, captured request PC and drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= 32'd0;
      drop     <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_next;
      drop     <= drop_next;
      if ((state == S_REQ) && imem_req_ready) begin
        req_pc <= imem_req_addr;
      end
    end
  end

  // Registered request channel; the address only changes on entry to S_REQ,
  // so it stays put across redirects until the memory accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req_valid <= 1'b0;
      imem_req_addr  <= 32'd0;
    end else begin
      imem_req_valid <= (state_next == S_REQ);
      if (load_req) begin
        imem_req_addr <= fetch_pc_next;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_next;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // FIFO storage written with the request PC and the returned word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i]   <= 32'd0;
        data_q[i] <= 32'd0;
        err_q[i]  <= 1'b0;
      end
    end else if (push) begin
      pc_q[wr_ptr]   <= req_pc;
      data_q[wr_ptr] <= imem_resp_data;
      err_q[wr_ptr]  <= imem_resp_err;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios plus randomized traffic checked
// against a stream-level model (the decoder must see consecutive words from
// the last redirect target, each carrying memory's data/err for its address).
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
  );

  int errors = 0;
  int checks = 0;

  // stimulus knobs
  bit          rand_mode = 0;
  logic        d_ready = 0, d_inst_ready = 0, d_redirect = 0;
  logic [31:0] d_redirect_pc = 32'd0;
  int          mem_lat = 1;
  logic [31:0] key = 32'd0;
  logic [31:0] err_addr = 32'd1;
  bit          err_pat = 0;
  bit          stray_resp = 0;

  // reference model
  logic [31:0] exp_pc;
  int          occ;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  bit          pend_stale;
  bit          cur_stale;
  bit          prev_req_valid;
  logic [31:0] prev_req_addr;
  bit          prev_accept;
  int          cyc;
  int          first_valid_cyc;
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];
  bit          pop_err_q[$];
  int          pop_cyc_q[$];
  logic [31:0] acc_addr_q[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ key;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a == err_addr) || (err_pat && (a[5:2] == 4'hB));
  endfunction

  function automatic logic [31:0] pop_pc_at(input int i);
    return (pop_pc_q.size() > i) ? pop_pc_q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] pop_data_at(input int i);
    return (pop_data_q.size() > i) ? pop_data_q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] pop_err_at(input int i);
    return (pop_err_q.size() > i) ? {31'd0, pop_err_q[i]} : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] acc_at(input int i);
    return (acc_addr_q.size() > i) ? acc_addr_q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc = RESET_PC;
    occ = 0;
    pend = 0;
    pend_cnt = 0;
    pend_addr = 32'd0;
    pend_stale = 0;
    cur_stale = 0;
    prev_req_valid = 0;
    prev_req_addr = 32'd0;
    prev_accept = 0;
    cyc = 0;
    first_valid_cyc = -1;
    pop_pc_q.delete();
    pop_data_q.delete();
    pop_err_q.delete();
    pop_cyc_q.delete();
    acc_addr_q.delete();
  endtask

  // One cycle: compare outputs (stable since last posedge), drive inputs for
  // the next posedge, advance the model by the events of that posedge.
  task automatic tick();
    logic acc, pop, redir, resp;
    if (!rst) begin
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_inst_err", {31'd0, inst_err}, 32'd0);
      imem_resp_valid = 1'b0;
      @(negedge clk);
      return;
    end

    chk("inst_valid", {31'd0, inst_valid}, {31'd0, occ != 0});
    if (inst_valid) begin
      chk("head_pc", inst_pc, exp_pc);
      chk("head_data", inst, data_of(exp_pc));
      chk("head_err", {31'd0, inst_err}, {31'd0, err_of(exp_pc)});
    end else begin
      chk("empty_inst", inst, 32'd0);
      chk("empty_pc", inst_pc, 32'd0);
      chk("empty_err", {31'd0, inst_err}, 32'd0);
    end
    if (pend) chk("single_outstanding", {31'd0, imem_req_valid}, 32'd0);
    if (prev_req_valid && !prev_accept) begin
      chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_req_addr);
    end else if (imem_req_valid) begin
      chk("req_addr_next_word", imem_req_addr, exp_pc + 32'(4 * occ));
      chk("req_only_with_space", {31'd0, occ < DEPTH}, 32'd1);
      cur_stale = 0;
    end

    if (rand_mode) begin
      imem_req_ready = ($urandom_range(0, 99) < 60);
      inst_ready     = ($urandom_range(0, 99) < 55);
      redirect_valid = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        redirect_pc = 32'h8000_0000 + 32'($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 3));
    end else begin
      imem_req_ready = d_ready;
      inst_ready     = d_inst_ready;
      redirect_valid = d_redirect;
      redirect_pc    = d_redirect_pc;
    end

    resp = 0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) resp = 1;
    end
    if (resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = data_of(pend_addr);
      imem_resp_err   = err_of(pend_addr);
    end else if (stray_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      imem_resp_err   = 1'b1;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom_range(0, 1));
    end

    acc   = imem_req_valid & imem_req_ready;
    pop   = inst_valid & inst_ready;
    redir = redirect_valid;
    if (redir && (imem_req_valid || pend)) begin
      cur_stale  = 1;
      pend_stale = 1;
    end
    if (resp) begin
      if (!pend_stale) occ++;
      pend = 0;
    end
    if (acc) begin
      acc_addr_q.push_back(imem_req_addr);
      pend       = 1;
      pend_addr  = imem_req_addr;
      pend_stale = cur_stale;
      pend_cnt   = rand_mode ? int'($urandom_range(1, 4)) : mem_lat;
    end
    if (pop) begin
      pop_pc_q.push_back(inst_pc);
      pop_data_q.push_back(inst);
      pop_err_q.push_back(inst_err);
      pop_cyc_q.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
      if (occ > 0) occ--;
    end
    if (redir) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
      occ = 0;
    end
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    prev_req_valid = imem_req_valid;
    prev_req_addr  = imem_req_addr;
    prev_accept    = acc;
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge, checks reset values, releases it.
  // The first tick afterwards observes cycle 0; tick k observes cycle k.
  task automatic do_reset(input int n);
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    imem_resp_valid = 1'b0;
    stray_resp = 0;
    d_redirect = 0;
    model_reset();
    #1;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic run_until_acc(input int n, input int bound, input string name);
    int k = 0;
    while (acc_addr_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk(name, acc_addr_q.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // Idle memory: request appears in cycle 1 and holds.
    d_ready = 0; d_inst_ready = 0; mem_lat = 1; key = 32'd0; err_addr = 32'd1; err_pat = 0;
    do_reset(3);
    tick();
    chk("t1_req_valid_c1", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_req_addr_c1", imem_req_addr, 32'h8000_0000);
    repeat (6) tick();
    chk("t1_req_valid_hold", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_req_addr_hold", imem_req_addr, 32'h8000_0000);
    chk("t1_no_inst", {31'd0, inst_valid}, 32'd0);

    // Zero-wait memory, data = address, always consuming.
    d_ready = 1; d_inst_ready = 1;
    do_reset(2);
    repeat (12) tick();
    chk("t2_first_valid_cycle", first_valid_cyc, 3);
    chk("t2_pc0", pop_pc_at(0), 32'h8000_0000);
    chk("t2_data0", pop_data_at(0), 32'h8000_0000);
    chk("t2_pc1", pop_pc_at(1), 32'h8000_0004);
    chk("t2_data1", pop_data_at(1), 32'h8000_0004);
    chk("t2_pc2", pop_pc_at(2), 32'h8000_0008);
    chk("t2_data2", pop_data_at(2), 32'h8000_0008);
    if (pop_cyc_q.size() >= 3) begin
      chk("t2_gap01", {31'd0, (pop_cyc_q[1] - pop_cyc_q[0]) <= 2}, 32'd1);
      chk("t2_gap12", {31'd0, (pop_cyc_q[2] - pop_cyc_q[1]) <= 2}, 32'd1);
    end else begin
      chk("t2_pop_count", pop_cyc_q.size(), 3);
    end

    // Back-pressure: two words buffered, parked, then drain and resume.
    d_ready = 1; d_inst_ready = 0;
    do_reset(2);
    repeat (14) tick();
    chk("t3_two_requests", acc_addr_q.size(), 2);
    chk("t3_parked_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("t3_head_pc", inst_pc, 32'h8000_0000);
    d_inst_ready = 1;
    repeat (8) tick();
    chk("t3_drain_pc0", pop_pc_at(0), 32'h8000_0000);
    chk("t3_drain_pc1", pop_pc_at(1), 32'h8000_0004);
    chk("t3_resume_addr", acc_at(2), 32'h8000_0008);

    // Redirect while waiting for 0x80000004.
    d_ready = 1; d_inst_ready = 0; mem_lat = 3;
    do_reset(2);
    run_until_acc(2, 40, "t4_second_accept");
    chk("t4_waiting_addr", acc_at(1), 32'h8000_0004);
    d_redirect = 1; d_redirect_pc = 32'h8000_1002;
    tick();
    d_redirect = 0;
    chk("t4_flushed", {31'd0, inst_valid}, 32'd0);
    run_until_acc(3, 40, "t4_third_accept");
    chk("t4_redirect_addr", acc_at(2), 32'h8000_1000);
    d_inst_ready = 1;
    repeat (12) tick();
    chk("t4_first_pop_pc", pop_pc_at(0), 32'h8000_1000);
    chk("t4_first_pop_data", pop_data_at(0), 32'h8000_1000);

    // Redirect while parked in IDLE: new address one cycle later.
    d_ready = 1; d_inst_ready = 0; mem_lat = 1;
    do_reset(2);
    repeat (14) tick();
    chk("t5_parked", {31'd0, imem_req_valid}, 32'd0);
    d_redirect = 1; d_redirect_pc = 32'h8000_2000;
    tick();
    d_redirect = 0;
    chk("t5_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t5_req_addr", imem_req_addr, 32'h8000_2000);
    chk("t5_flushed", {31'd0, inst_valid}, 32'd0);

    // Access fault on the word at 0x80000004.
    d_ready = 1; d_inst_ready = 1; err_addr = 32'h8000_0004;
    do_reset(2);
    repeat (12) tick();
    chk("t6_err0", pop_err_at(0), 32'd0);
    chk("t6_pc1", pop_pc_at(1), 32'h8000_0004);
    chk("t6_err1", pop_err_at(1), 32'd1);
    chk("t6_pc2", pop_pc_at(2), 32'h8000_0008);
    chk("t6_err2", pop_err_at(2), 32'd0);
    err_addr = 32'd1;

    // Address wrap from the top of the space.
    d_ready = 1; d_inst_ready = 1;
    do_reset(2);
    d_redirect = 1; d_redirect_pc = 32'hFFFF_FFFB;
    tick();
    d_redirect = 0;
    repeat (12) tick();
    chk("t7_pc0", pop_pc_at(0), 32'hFFFF_FFF8);
    chk("t7_pc1", pop_pc_at(1), 32'hFFFF_FFFC);
    chk("t7_pc2", pop_pc_at(2), 32'h0000_0000);

    // Reset in WAIT, stray response after release.
    d_ready = 1; d_inst_ready = 1; mem_lat = 4;
    do_reset(2);
    run_until_acc(1, 20, "t8_accept");
    tick();
    do_reset(3);
    d_ready = 0;
    stray_resp = 1;
    tick();
    tick();
    stray_resp = 0;
    chk("t8_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t8_req_addr", imem_req_addr, 32'h8000_0000);
    chk("t8_no_inst", {31'd0, inst_valid}, 32'd0);
    d_ready = 1;
    repeat (14) tick();
    chk("t8_first_pc", pop_pc_at(0), 32'h8000_0000);
    chk("t8_first_data", pop_data_at(0), 32'h8000_0000);

    // Randomized traffic against the stream model.
    key = $urandom; err_pat = 1; err_addr = 32'd1;
    do_reset(2);
    rand_mode = 1;
    repeat (4000) tick();
    rand_mode = 0;
    chk("rand_progress", {31'd0, pop_pc_q.size() > 100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
